// File: rtl/dmem_bus_adapter_pkg.sv
// Shared types and defaults for the data-memory bus adapter.
package dmem_bus_adapter_pkg;

    typedef logic [31:0] uint32_t;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} dmem_state_t;

    localparam int unsigned DMEM_TIMEOUT_DEFAULT = 255;
    localparam int unsigned DMEM_ADDR_W_DEFAULT  = 30;

endpackage

// File: rtl/dmem_bus_adapter_if.sv
// Valid/ready data-memory bus between the adapter (master) and the memory or fabric (slave).
interface dmem_bus_adapter_if
    import dmem_bus_adapter_pkg::*;
#(
    parameter int unsigned ADDR_W = DMEM_ADDR_W_DEFAULT
);

    logic              mem_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    uint32_t           mem_wdata;
    logic              mem_ready;
    uint32_t           mem_rdata;
    logic              mem_err;

    modport master (
        output mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rdata, mem_err
    );

    modport slave (
        input  mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rdata, mem_err
    );

endinterface

// File: rtl/bus_timeout_counter.sv
// Counts ACCESS cycles; expired flags the last permitted cycle of an outstanding access.
module bus_timeout_counter
    import dmem_bus_adapter_pkg::*;
#(
    parameter int unsigned LIMIT = DMEM_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    logic [7:0] count_q, count_d;

    assign expired = en && (count_q == 8'(LIMIT - 1));

    // Holds at the limit so the count can never wrap into a fresh window.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en && !expired) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/dmem_bus_adapter.sv
// Sequential load/store port: one access per instruction, stalls the core while outstanding,
// registered read data, bus errors and timeouts reported as a bus_err pulse with done.
module dmem_bus_adapter
    import dmem_bus_adapter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT,
    parameter int unsigned ADDR_W         = DMEM_ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_mask,
    input  uint32_t           req_wdata,
    output logic              stall,
    output logic              done,
    output uint32_t           rdata,
    output logic              bus_err,
    dmem_bus_adapter_if.master bus
);

    localparam logic [1:0] StIdle   = IDLE;
    localparam logic [1:0] StAccess = ACCESS;
    localparam logic [1:0] StDone   = DONE;

    logic [1:0]        state_q, state_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    uint32_t           wdata_q, wdata_d;
    uint32_t           rdata_q, rdata_d;

    logic request, squashed, in_idle, in_access, expired;

    assign request   = req_read | req_write;
    // A store whose mask was cleared upstream completes without touching the bus.
    assign squashed  = req_write && (req_mask == 4'b0000);
    assign in_idle   = (state_q == StIdle);
    assign in_access = (state_q == StAccess);

    bus_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (in_idle && request),
        .en      (in_access),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            StIdle: begin
                if (request) begin
                    err_d = 1'b0;
                    if (squashed) begin
                        state_d = StDone;
                    end else begin
                        state_d = StAccess;
                        we_d    = req_write;
                        addr_d  = req_addr;
                        be_d    = req_mask;
                        wdata_d = req_wdata;
                    end
                end
            end
            StAccess: begin
                // mem_ready takes precedence over a timeout in the same cycle.
                if (bus.mem_ready) begin
                    state_d = StDone;
                    err_d   = bus.mem_err;
                    if (!we_q) rdata_d = bus.mem_rdata;
                end else if (expired) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                    if (!we_q) rdata_d = '0;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign stall         = (in_idle && request) || in_access;
    assign done          = (state_q == StDone);
    assign bus_err       = done && err_q;
    assign rdata         = rdata_q;
    assign bus.mem_valid = in_access;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_bus_adapter.sv
// Directed bench for dmem_bus_adapter: a transaction-level timing model drives per-cycle
// expectations checked on every falling edge, plus hand-computed literal pins.
module tb_dmem_bus_adapter;

    localparam int unsigned T  = 4;
    localparam int unsigned AW = 30;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_read, req_write;
    logic [AW-1:0] req_addr;
    logic [3:0]    req_mask;
    logic [31:0]   req_wdata;
    logic          stall, done, bus_err;
    logic [31:0]   rdata;

    dmem_bus_adapter_if #(.ADDR_W(AW)) bus ();

    dmem_bus_adapter #(
        .TIMEOUT_CYCLES (T),
        .ADDR_W         (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_read  (req_read),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_mask  (req_mask),
        .req_wdata (req_wdata),
        .stall     (stall),
        .done      (done),
        .rdata     (rdata),
        .bus_err   (bus_err),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic          chk_en = 1'b0;
    logic          exp_stall, exp_valid, exp_done, exp_err, exp_we;
    logic [AW-1:0] exp_addr;
    logic [3:0]    exp_be;
    logic [31:0]   exp_wdata, exp_rdata;

    int   valid_cnt, done_cnt, done_cyc, txn_start;
    logic last_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall",     32'(stall),         32'(exp_stall));
            chk("done",      32'(done),          32'(exp_done));
            chk("bus_err",   32'(bus_err),       32'(exp_err));
            chk("mem_valid", 32'(bus.mem_valid), 32'(exp_valid));
            chk("rdata",     rdata,              exp_rdata);
            if (exp_valid) begin
                chk("mem_we",    32'(bus.mem_we),   32'(exp_we));
                chk("mem_addr",  32'(bus.mem_addr), 32'(exp_addr));
                chk("mem_be",    32'(bus.mem_be),   32'(exp_be));
                chk("mem_wdata", bus.mem_wdata,     exp_wdata);
            end
            if (bus.mem_valid) valid_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                last_err = bus_err;
            end
        end
    end

    task automatic idle(input int n, input bit junk);
        for (int i = 0; i < n; i++) begin
            req_read      = 1'b0;
            req_write     = 1'b0;
            bus.mem_ready = junk;
            bus.mem_err   = junk;
            bus.mem_rdata = junk ? 32'hBAD0BAD0 : 32'h0;
            exp_stall = 1'b0;
            exp_valid = 1'b0;
            exp_done  = 1'b0;
            exp_err   = 1'b0;
            @(posedge clk); #1;
        end
        bus.mem_ready = 1'b0;
        bus.mem_err   = 1'b0;
    endtask

    // ready_at: cycle (relative to the request cycle 0) at which mem_ready pulses; 0 = never.
    // rst_at: relative cycle in which reset is asserted; -1 = none.
    task automatic run_txn(input bit rd, input bit wr, input logic [AW-1:0] addr,
                           input logic [3:0] mask, input logic [31:0] wdata,
                           input int ready_at, input bit err, input logic [31:0] mrdata,
                           input bit tied, input int rst_at);
        bit          squash;
        bit          rdy;
        int          last_acc;
        int          last;
        logic [31:0] next_rdata;
        squash     = wr && (mask == 4'h0);
        rdy        = !squash && (ready_at >= 1) && (ready_at <= int'(T));
        last_acc   = squash ? 0 : (rdy ? ready_at : int'(T));
        last       = (rst_at >= 0) ? rst_at : last_acc + 1;
        next_rdata = wr ? exp_rdata : (rdy ? mrdata : 32'h0);
        valid_cnt  = 0;
        done_cnt   = 0;
        txn_start  = cyc;
        for (int i = 0; i <= last; i++) begin
            req_read      = rd && (i <= last_acc);
            req_write     = wr && (i <= last_acc);
            req_addr      = addr;
            req_mask      = mask;
            req_wdata     = wdata;
            bus.mem_ready = tied || (i == ready_at && !squash);
            bus.mem_err   = err && (i == ready_at);
            bus.mem_rdata = mrdata;
            rst           = (i == rst_at);
            exp_stall = (i <= last_acc);
            exp_valid = !squash && (i >= 1) && (i <= last_acc);
            exp_done  = (i == last_acc + 1);
            exp_err   = exp_done && !squash && (rdy ? err : 1'b1);
            exp_we    = wr;
            exp_addr  = addr;
            exp_be    = mask;
            exp_wdata = wdata;
            if (exp_done) exp_rdata = next_rdata;
            @(posedge clk); #1;
        end
        rst           = 1'b0;
        req_read      = 1'b0;
        req_write     = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_err   = 1'b0;
        if (rst_at >= 0) exp_rdata = 32'h0;
    endtask

    initial begin
        rst = 1'b1;
        req_read = 1'b0; req_write = 1'b0;
        req_addr = '0; req_mask = '0; req_wdata = '0;
        bus.mem_ready = 1'b0; bus.mem_err = 1'b0; bus.mem_rdata = '0;
        exp_stall = 1'b0; exp_valid = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
        exp_we = 1'b0; exp_addr = '0; exp_be = '0; exp_wdata = '0; exp_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        chk("reset mem_we",    32'(bus.mem_we),   32'h0);
        chk("reset mem_addr",  32'(bus.mem_addr), 32'h0);
        chk("reset mem_be",    32'(bus.mem_be),   32'h0);
        chk("reset mem_wdata", bus.mem_wdata,     32'h0);
        idle(2, 1'b1);

        // Zero-wait read, ready tied high.
        run_txn(1, 0, 30'h10, 4'hF, 32'h0, 1, 0, 32'hDEADBEEF, 1, -1);
        chk("zw done cycle", 32'(done_cyc - txn_start), 32'd2);
        chk("zw rdata",      rdata,                     32'hDEADBEEF);
        chk("zw valid cnt",  32'(valid_cnt),            32'd1);
        idle(1, 1'b1);

        // Three wait states on a write.
        run_txn(0, 1, 30'h2A, 4'b0110, 32'h12345678, 4, 0, 32'hFFFFFFFF, 0, -1);
        chk("ws done cycle", 32'(done_cyc - txn_start), 32'd5);
        chk("ws valid cnt",  32'(valid_cnt),            32'd4);
        chk("ws rdata kept", rdata,                     32'hDEADBEEF);

        // Timeout on a read, back to back with the write.
        run_txn(1, 0, 30'h3, 4'hF, 32'h0, 0, 0, 32'h11111111, 0, -1);
        chk("to done cycle", 32'(done_cyc - txn_start), 32'd5);
        chk("to valid cnt",  32'(valid_cnt),            32'd4);
        chk("to bus_err",    32'(last_err),             32'd1);
        chk("to rdata",      rdata,                     32'h0);
        idle(1, 1'b0);

        // Bus error on a write.
        run_txn(0, 1, 30'h7, 4'hF, 32'hA5A5A5A5, 2, 1, 32'h0, 0, -1);
        chk("be done cycle", 32'(done_cyc - txn_start), 32'd3);
        chk("be bus_err",    32'(last_err),             32'd1);

        // Squashed store, then simultaneous read+write.
        run_txn(0, 1, 30'h9, 4'h0, 32'h77777777, 1, 0, 32'h0, 0, -1);
        chk("sq done cycle", 32'(done_cyc - txn_start), 32'd1);
        chk("sq valid cnt",  32'(valid_cnt),            32'd0);
        chk("sq bus_err",    32'(last_err),             32'd0);
        run_txn(1, 1, 30'h1F, 4'hF, 32'h0F0F0F0F, 1, 0, 32'h22222222, 0, -1);
        idle(2, 1'b0);
        chk("rw valid cnt",  32'(valid_cnt),            32'd1);
        chk("rw done cnt",   32'(done_cnt),             32'd1);

        // Ready in the final timeout cycle wins.
        run_txn(1, 0, 30'h44, 4'hF, 32'h0, 4, 0, 32'hCAFEF00D, 0, -1);
        chk("lt bus_err",    32'(last_err),             32'd0);
        chk("lt rdata",      rdata,                     32'hCAFEF00D);

        // Read returning an error still captures data.
        run_txn(1, 0, 30'h45, 4'hF, 32'h0, 2, 1, 32'h13572468, 0, -1);
        chk("re bus_err",    32'(last_err),             32'd1);
        chk("re rdata",      rdata,                     32'h13572468);
        idle(1, 1'b0);

        // Reset during the second ACCESS cycle, then a fresh read.
        run_txn(1, 0, 30'h50, 4'hF, 32'h0, 0, 0, 32'h0, 0, 2);
        idle(2, 1'b0);
        chk("rm done cnt",   32'(done_cnt),             32'd0);
        chk("rm rdata",      rdata,                     32'h0);
        run_txn(1, 0, 30'h3FFFFFFF, 4'hF, 32'h0, 1, 0, 32'h55AA55AA, 0, -1);
        chk("fr done cycle", 32'(done_cyc - txn_start), 32'd2);
        chk("fr rdata",      rdata,                     32'h55AA55AA);
        idle(2, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
